// File: rtl/reg_seq_ctrl_pkg.sv
// Shared encodings and the fixed test table for the dual shift-register check sequencer.
package reg_seq_ctrl_pkg;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_RUN   = 3'd2,
        S_DRAIN = 3'd3,
        S_NEXT  = 3'd4,
        S_FIN   = 3'd5
    } state_e;

    typedef enum logic [1:0] {
        MODO_SHIFT = 2'b00,
        MODO_ROT   = 2'b01,
        MODO_LOAD  = 2'b10
    } modo_e;

    typedef enum logic {
        DIR_L = 1'b0,
        DIR_R = 1'b1
    } dir_e;

    typedef struct packed {
        logic  enb;
        modo_e modo;
        dir_e  dir;
        logic  s_in;
    } step_t;

    localparam int CYC_W = 16;

    function automatic logic [31:0] seed_f(input logic [2:0] t);
        logic [31:0] s;
        case (t)
            3'd0:    s = 32'hA5A5_F00F;
            3'd1:    s = 32'h0000_0001;
            3'd2:    s = 32'h8000_0000;
            3'd3:    s = 32'hDEAD_BEEF;
            3'd4:    s = 32'h1234_5678;
            default: s = 32'h0000_0000;
        endcase
        return s;
    endfunction

    // Entries past test 4 behave as a hold test so NTESTS up to 8 stays well defined.
    function automatic step_t step_f(input logic [2:0] t);
        step_t s;
        case (t)
            3'd0:    s = '{enb: 1'b1, modo: MODO_SHIFT, dir: DIR_L, s_in: 1'b1};
            3'd1:    s = '{enb: 1'b1, modo: MODO_SHIFT, dir: DIR_R, s_in: 1'b0};
            3'd2:    s = '{enb: 1'b1, modo: MODO_ROT,   dir: DIR_L, s_in: 1'b0};
            3'd3:    s = '{enb: 1'b1, modo: MODO_ROT,   dir: DIR_R, s_in: 1'b0};
            default: s = '{enb: 1'b0, modo: MODO_SHIFT, dir: DIR_L, s_in: 1'b0};
        endcase
        return s;
    endfunction

endpackage

// File: rtl/reg_seq_ctrl_if.sv
// Stimulus, response and status bundle between the sequencer and the two registers under check.
interface reg_seq_ctrl_if #(
    parameter int WIDTH  = 32,
    parameter int SOUT_W = 8,
    parameter int CNT_W  = 16
);
    logic              START;
    logic              ENB;
    logic              DIR;
    logic [1:0]        MODO;
    logic              S_IN;
    logic [WIDTH-1:0]  D;
    logic [WIDTH-1:0]  Q_A;
    logic [WIDTH-1:0]  Q_B;
    logic [SOUT_W-1:0] SOUT_A;
    logic [SOUT_W-1:0] SOUT_B;
    logic              BUSY;
    logic              DONE;
    logic              PASS;
    logic [CNT_W-1:0]  ERR_COUNT;
    logic [2:0]        FIRST_TEST;
    logic [7:0]        FIRST_CYC;

    modport master (
        input  START, Q_A, Q_B, SOUT_A, SOUT_B,
        output ENB, DIR, MODO, S_IN, D, BUSY, DONE, PASS, ERR_COUNT, FIRST_TEST, FIRST_CYC
    );

    modport slave (
        output START, Q_A, Q_B, SOUT_A, SOUT_B,
        input  ENB, DIR, MODO, S_IN, D, BUSY, DONE, PASS, ERR_COUNT, FIRST_TEST, FIRST_CYC
    );
endinterface

// File: rtl/reg_seq_ctrl_cmp.sv
// Registered A/B compare: saturating mismatch count, first-failure capture and end-of-run PASS.
module reg_seq_ctrl_cmp
    import reg_seq_ctrl_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int SOUT_W = 8,
    parameter int CNT_W  = 16
) (
    input  logic              CLK,
    input  logic              RESET_L,
    input  logic              cmp_en_i,
    input  logic              clr_i,
    input  logic              fin_i,
    input  logic [2:0]        test_i,
    input  logic [CYC_W-1:0]  cyc_i,
    input  logic [WIDTH-1:0]  q_a_i,
    input  logic [WIDTH-1:0]  q_b_i,
    input  logic [SOUT_W-1:0] sout_a_i,
    input  logic [SOUT_W-1:0] sout_b_i,
    output logic [CNT_W-1:0]  err_count_o,
    output logic [2:0]        first_test_o,
    output logic [7:0]        first_cyc_o,
    output logic              pass_o
);
    logic [CNT_W-1:0] err_q, err_d;
    logic             vld_q, vld_d;
    logic [2:0]       ftest_q, ftest_d;
    logic [7:0]       fcyc_q, fcyc_d;
    logic             pass_q, pass_d;
    logic             hit;

    always_ff @(posedge CLK or negedge RESET_L) begin
        if (!RESET_L) begin
            err_q   <= '0;
            vld_q   <= 1'b0;
            ftest_q <= '0;
            fcyc_q  <= '0;
            pass_q  <= 1'b0;
        end else begin
            err_q   <= err_d;
            vld_q   <= vld_d;
            ftest_q <= ftest_d;
            fcyc_q  <= fcyc_d;
            pass_q  <= pass_d;
        end
    end

    // Case inequality so an X/Z on either side is a mismatch in simulation.
    always_comb begin
        hit     = cmp_en_i && ((q_a_i !== q_b_i) || (sout_a_i !== sout_b_i));
        err_d   = err_q;
        vld_d   = vld_q;
        ftest_d = ftest_q;
        fcyc_d  = fcyc_q;
        if (clr_i) begin
            err_d   = '0;
            vld_d   = 1'b0;
            ftest_d = '0;
            fcyc_d  = '0;
        end else if (hit) begin
            if (err_q != {CNT_W{1'b1}}) err_d = err_q + 1'b1;
            if (!vld_q) begin
                vld_d   = 1'b1;
                ftest_d = test_i;
                fcyc_d  = (|cyc_i[CYC_W-1:8]) ? 8'hFF : cyc_i[7:0];
            end
        end
        // PASS must include the compare landing on the FIN edge, hence err_d.
        pass_d = clr_i ? 1'b0 : (fin_i ? (err_d == '0) : pass_q);
    end

    assign err_count_o  = err_q;
    assign first_test_o = ftest_q;
    assign first_cyc_o  = fcyc_q;
    assign pass_o       = pass_q;
endmodule

// File: rtl/reg_seq_ctrl.sv
// Sequencer for the dual shift-register check: steps the fixed test table, drives both registers,
// and hands their responses to the compare block one cycle later.
//   state   | meaning
//   S_IDLE  | waiting for START, outputs quiet
//   S_LOAD  | parallel load of SEED[test]
//   S_RUN   | SHIFT_CYCLES cycles of the test-table operation
//   S_DRAIN | ENB low, last RUN update gets compared
//   S_NEXT  | advance to next test
//   S_FIN   | last compare lands; DONE/PASS register on this edge
module reg_seq_ctrl
    import reg_seq_ctrl_pkg::*;
#(
    parameter int WIDTH        = 32,
    parameter int SOUT_W       = 8,
    parameter int NTESTS       = 5,
    parameter int SHIFT_CYCLES = 40,
    parameter int CNT_W        = 16
) (
    input  logic           CLK,
    input  logic           RESET_L,
    reg_seq_ctrl_if.master bus
);
    localparam logic [2:0]       LAST_TEST = 3'(NTESTS - 1);
    localparam logic [CYC_W-1:0] LAST_CYC  = CYC_W'(SHIFT_CYCLES - 1);

    state_e            state_q, state_d;
    logic [2:0]        test_q, test_d;
    logic [CYC_W-1:0]  cyc_q, cyc_d;
    logic              cmp_en_q, done_q;
    logic [2:0]        cmp_test_q;
    logic [CYC_W-1:0]  cmp_cyc_q;
    logic              enb, s_in, busy, cmp_en, clr, fin;
    modo_e             modo;
    dir_e              dir;
    logic [WIDTH-1:0]  d, d_seed;
    logic [31:0]       seed;
    step_t             step;

    always_ff @(posedge CLK or negedge RESET_L) begin
        if (!RESET_L) begin
            state_q    <= S_IDLE;
            test_q     <= '0;
            cyc_q      <= '0;
            cmp_en_q   <= 1'b0;
            cmp_test_q <= '0;
            cmp_cyc_q  <= '0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            test_q     <= test_d;
            cyc_q      <= cyc_d;
            cmp_en_q   <= cmp_en;
            cmp_test_q <= test_q;
            cmp_cyc_q  <= cyc_q;
            done_q     <= fin;
        end
    end

    always_comb begin
        state_d = state_q;
        test_d  = test_q;
        cyc_d   = cyc_q;
        case (state_q)
            S_IDLE: if (bus.START) begin
                state_d = S_LOAD;
                test_d  = '0;
                cyc_d   = '0;
            end
            S_LOAD:  state_d = S_RUN;
            S_RUN: begin
                cyc_d = cyc_q + 1'b1;
                if (cyc_q == LAST_CYC) state_d = S_DRAIN;
            end
            S_DRAIN: state_d = (test_q == LAST_TEST) ? S_FIN : S_NEXT;
            S_NEXT: begin
                state_d = S_LOAD;
                test_d  = test_q + 1'b1;
                cyc_d   = '0;
            end
            default: state_d = S_IDLE;
        endcase
    end

    generate
        if (WIDTH > 32) begin : g_seed_ext
            assign d_seed = {{(WIDTH - 32){1'b0}}, seed};
        end else begin : g_seed_trunc
            assign d_seed = seed[WIDTH-1:0];
        end
    endgenerate

    always_comb begin
        seed   = seed_f(test_q);
        step   = step_f(test_q);
        enb    = 1'b0;
        modo   = MODO_SHIFT;
        dir    = DIR_L;
        s_in   = 1'b0;
        d      = '0;
        busy   = 1'b0;
        cmp_en = 1'b0;
        case (state_q)
            S_LOAD: begin
                enb    = 1'b1;
                modo   = MODO_LOAD;
                d      = d_seed;
                busy   = 1'b1;
                cmp_en = 1'b1;
            end
            S_RUN: begin
                enb    = step.enb;
                modo   = step.modo;
                dir    = step.dir;
                s_in   = step.s_in;
                busy   = 1'b1;
                cmp_en = 1'b1;
            end
            S_DRAIN: begin
                busy   = 1'b1;
                cmp_en = 1'b1;
            end
            S_NEXT:  busy = 1'b1;
            default: ;
        endcase
        clr = (state_q == S_IDLE) && bus.START;
        fin = (state_q == S_FIN);
    end

    assign bus.ENB  = enb;
    assign bus.MODO = modo;
    assign bus.DIR  = dir;
    assign bus.S_IN = s_in;
    assign bus.D    = d;
    assign bus.BUSY = busy;
    assign bus.DONE = done_q;

    reg_seq_ctrl_cmp #(
        .WIDTH  (WIDTH),
        .SOUT_W (SOUT_W),
        .CNT_W  (CNT_W)
    ) u_cmp (
        .CLK          (CLK),
        .RESET_L      (RESET_L),
        .cmp_en_i     (cmp_en_q),
        .clr_i        (clr),
        .fin_i        (fin),
        .test_i       (cmp_test_q),
        .cyc_i        (cmp_cyc_q),
        .q_a_i        (bus.Q_A),
        .q_b_i        (bus.Q_B),
        .sout_a_i     (bus.SOUT_A),
        .sout_b_i     (bus.SOUT_B),
        .err_count_o  (bus.ERR_COUNT),
        .first_test_o (bus.FIRST_TEST),
        .first_cyc_o  (bus.FIRST_CYC),
        .pass_o       (bus.PASS)
    );
endmodule

// File: tb/tb_reg_seq_ctrl.sv
// Directed bench: two shift-register models with fault hooks on B, plus a 4-bit-counter instance
// fed a permanent mismatch.
module tb_reg_seq_ctrl;
    logic CLK = 1'b0;
    logic RESET_L = 1'b0;
    always #5 CLK = ~CLK;

    reg_seq_ctrl_if #(.WIDTH(32), .SOUT_W(8), .CNT_W(16)) bus ();
    reg_seq_ctrl_if #(.WIDTH(32), .SOUT_W(8), .CNT_W(4))  bus4 ();

    reg_seq_ctrl #(.WIDTH(32), .SOUT_W(8), .NTESTS(5), .SHIFT_CYCLES(40), .CNT_W(16)) dut (
        .CLK(CLK), .RESET_L(RESET_L), .bus(bus));
    reg_seq_ctrl #(.WIDTH(32), .SOUT_W(8), .NTESTS(5), .SHIFT_CYCLES(40), .CNT_W(4)) dut4 (
        .CLK(CLK), .RESET_L(RESET_L), .bus(bus4));

    logic        stuck0 = 1'b0, flip = 1'b0, ign = 1'b0;
    logic [31:0] ra, rb;
    int          n_chk = 0, n_fail = 0, edge_cnt = 0, start_cnt = 0, done_cnt = 0;
    int          lat, snap;

    function automatic logic [31:0] nxt(input logic [31:0] q, input logic [1:0] m,
                                        input logic dr, input logic si, input logic [31:0] d);
        logic [31:0] r;
        case (m)
            2'b00:   r = dr ? {si, q[31:1]} : {q[30:0], si};
            2'b01:   r = dr ? {q[0], q[31:1]} : {q[30:0], q[31]};
            2'b10:   r = d;
            default: r = q;
        endcase
        return r;
    endfunction

    always @(posedge CLK or negedge RESET_L) begin
        if (!RESET_L) begin
            ra <= '0;
            rb <= '0;
        end else begin
            if (bus.ENB) ra <= nxt(ra, bus.MODO, bus.DIR, bus.S_IN, bus.D);
            if (bus.ENB || ign) rb <= nxt(rb, bus.MODO, bus.DIR, bus.S_IN, bus.D);
        end
    end

    assign bus.Q_A    = ra;
    assign bus.Q_B    = rb & ~{31'b0, stuck0};
    assign bus.SOUT_A = ra[7:0];
    assign bus.SOUT_B = rb[7:0] ^ {7'b0, flip};

    assign bus4.START  = bus.START;
    assign bus4.Q_A    = '0;
    assign bus4.Q_B    = '1;
    assign bus4.SOUT_A = '0;
    assign bus4.SOUT_B = '0;

    always @(posedge CLK) edge_cnt <= edge_cnt + 1;
    always @(negedge CLK) if (bus.DONE) done_cnt <= done_cnt + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick_to(input int n);
        while (edge_cnt - start_cnt < n) begin
            @(posedge CLK);
            #1;
        end
    endtask

    task automatic run_start();
        bus.START = 1'b1;
        @(posedge CLK);
        #1;
        bus.START = 1'b0;
        start_cnt = edge_cnt - 1;
    endtask

    task automatic wait_done(output int l);
        l = -1;
        for (int i = 0; i < 400; i++) begin
            @(posedge CLK);
            #1;
            if (bus.DONE) begin
                l = edge_cnt - start_cnt - 1;
                break;
            end
        end
        check("done_seen", 32'(bus.DONE), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.START = 1'b0;
        #3;
        check("rst_busy", 32'(bus.BUSY), 32'd0);
        check("rst_enb",  32'(bus.ENB),  32'd0);
        check("rst_d",    bus.D,         32'd0);
        check("rst_err",  32'(bus.ERR_COUNT), 32'd0);
        check("rst_pass", 32'(bus.PASS), 32'd0);
        check("rst_done", 32'(bus.DONE), 32'd0);
        repeat (3) @(negedge CLK);
        RESET_L = 1'b1;
        @(posedge CLK);
        #1;

        // Clean run
        run_start();
        check("s1_busy", 32'(bus.BUSY), 32'd1);
        check("s1_load_enb", 32'(bus.ENB), 32'd1);
        check("s1_load_modo", 32'(bus.MODO), 32'd2);
        check("s1_load_d", bus.D, 32'hA5A5_F00F);
        tick_to(2);
        check("s1_t0_modo", 32'(bus.MODO), 32'd0);
        check("s1_t0_dir", 32'(bus.DIR), 32'd0);
        check("s1_t0_sin", 32'(bus.S_IN), 32'd1);
        tick_to(45);
        check("s1_t1_dir", 32'(bus.DIR), 32'd1);
        check("s1_t1_sin", 32'(bus.S_IN), 32'd0);
        tick_to(174);
        check("s1_t4_enb", 32'(bus.ENB), 32'd0);
        check("s1_t4_busy", 32'(bus.BUSY), 32'd1);
        wait_done(lat);
        check("s1_latency", 32'(lat), 32'd215);
        check("s1_pass", 32'(bus.PASS), 32'd1);
        check("s1_err", 32'(bus.ERR_COUNT), 32'd0);
        check("s1_busy_end", 32'(bus.BUSY), 32'd0);
        check("s1_qa_hold", bus.Q_A, 32'h1234_5678);
        check("s6_sat_done", 32'(bus4.DONE), 32'd1);
        check("s6_sat_err", 32'(bus4.ERR_COUNT), 32'd15);
        check("s6_sat_pass", 32'(bus4.PASS), 32'd0);
        check("s6_sat_ftest", 32'(bus4.FIRST_TEST), 32'd0);
        check("s6_sat_fcyc", 32'(bus4.FIRST_CYC), 32'd0);
        @(posedge CLK);
        #1;
        check("s1_done_pulse", 32'(bus.DONE), 32'd0);
        check("s1_pass_held", 32'(bus.PASS), 32'd1);

        // B Q[0] stuck-at-0 for test 0 only: 42 compares, all with A bit0 = 1
        run_start();
        check("s2_pass_clr", 32'(bus.PASS), 32'd0);
        stuck0 = 1'b1;
        tick_to(44);
        stuck0 = 1'b0;
        wait_done(lat);
        check("s2_err", 32'(bus.ERR_COUNT), 32'd42);
        check("s2_ftest", 32'(bus.FIRST_TEST), 32'd0);
        check("s2_fcyc", 32'(bus.FIRST_CYC), 32'd0);
        check("s2_pass", 32'(bus.PASS), 32'd0);

        // SOUT_B flip on the compare of test 3, cyc 7
        run_start();
        check("s3_err_clr", 32'(bus.ERR_COUNT), 32'd0);
        tick_to(139);
        flip = 1'b1;
        tick_to(140);
        flip = 1'b0;
        wait_done(lat);
        check("s3_err", 32'(bus.ERR_COUNT), 32'd1);
        check("s3_ftest", 32'(bus.FIRST_TEST), 32'd3);
        check("s3_fcyc", 32'(bus.FIRST_CYC), 32'd7);
        check("s3_pass", 32'(bus.PASS), 32'd0);

        // START while busy, at FIN, and one cycle after FIN
        run_start();
        snap = done_cnt;
        tick_to(50);
        bus.START = 1'b1;
        tick_to(51);
        bus.START = 1'b0;
        check("s5_busy_ign", 32'(bus.BUSY), 32'd1);
        tick_to(215);
        check("s5_fin_busy", 32'(bus.BUSY), 32'd0);
        check("s5_fin_done", 32'(bus.DONE), 32'd0);
        bus.START = 1'b1;
        tick_to(216);
        check("s5_done", 32'(bus.DONE), 32'd1);
        check("s5_fin_start_ign", 32'(bus.BUSY), 32'd0);
        tick_to(217);
        bus.START = 1'b0;
        check("s5_restart", 32'(bus.BUSY), 32'd1);
        start_cnt = edge_cnt - 1;
        wait_done(lat);
        check("s5_latency", 32'(lat), 32'd215);
        check("s5_pass", 32'(bus.PASS), 32'd1);
        @(posedge CLK);
        #1;
        check("s5_done_cnt", 32'(done_cnt - snap), 32'd2);

        // B ignores ENB during test 4: compares 175..215 mismatch
        run_start();
        tick_to(173);
        ign = 1'b1;
        wait_done(lat);
        ign = 1'b0;
        check("s6_hold_err", 32'(bus.ERR_COUNT), 32'd41);
        check("s6_hold_ftest", 32'(bus.FIRST_TEST), 32'd4);
        check("s6_hold_fcyc", 32'(bus.FIRST_CYC), 32'd0);
        check("s6_hold_pass", 32'(bus.PASS), 32'd0);

        // Reset at test 2, cyc 10
        run_start();
        tick_to(50);
        flip = 1'b1;
        tick_to(51);
        flip = 1'b0;
        tick_to(98);
        check("s4_pre_err", 32'(bus.ERR_COUNT), 32'd1);
        check("s4_pre_ftest", 32'(bus.FIRST_TEST), 32'd1);
        check("s4_pre_fcyc", 32'(bus.FIRST_CYC), 32'd4);
        snap = done_cnt;
        #2;
        RESET_L = 1'b0;
        #1;
        check("s4_busy", 32'(bus.BUSY), 32'd0);
        check("s4_enb", 32'(bus.ENB), 32'd0);
        check("s4_modo", 32'(bus.MODO), 32'd0);
        check("s4_err", 32'(bus.ERR_COUNT), 32'd0);
        check("s4_ftest", 32'(bus.FIRST_TEST), 32'd0);
        check("s4_fcyc", 32'(bus.FIRST_CYC), 32'd0);
        repeat (3) @(negedge CLK);
        RESET_L = 1'b1;
        @(posedge CLK);
        #1;
        check("s4_no_done", 32'(done_cnt - snap), 32'd0);
        run_start();
        wait_done(lat);
        check("s4_latency", 32'(lat), 32'd215);
        check("s4_pass", 32'(bus.PASS), 32'd1);
        check("s4_err_clean", 32'(bus.ERR_COUNT), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
